pc_sequencer: RTL and testbench

//  Run controller for the MIPS fetch stage. Arbitrates the next-PC value (PC+4, branch target, jump target) and

---
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: run controller for the MIPS fetch stage.
// Selects the next PC (jump > branch > PC+4), drives the PC hold line and
// sequences continuous run, debug single-step and the HALT drain.
module pc_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_step_mode,
  input  logic                   i_step,
  input  logic [DATA_WIDTH-1:0]  i_pc,
  input  logic                   i_stall,
  input  logic                   i_branch_taken,
  input  logic [DATA_WIDTH-1:0]  i_branch_target,
  input  logic                   i_jump,
  input  logic [DATA_WIDTH-1:0]  i_jump_target,
  input  logic                   i_halt_decoded,
  output logic [DATA_WIDTH-1:0]  o_pc_mux,
  output logic                   o_haltsignal,
  output logic                   o_flush,
  output logic [2:0]             o_state,
  output logic [COUNT_WIDTH-1:0] o_cycle_count,
  output logic                   o_done
);

  // Counter only ever holds DRAIN_CYCLES-1 down to 0.
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0]     DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = {COUNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [DRAIN_W-1:0]       drain_q, drain_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     done_q, done_d;

  logic                     advance;
  logic                     halt_accept;
  logic                     count_en;

  // Moore decode of the state register plus the combinational next-PC mux.
  always_comb begin
    advance      = (state_q == S_RUN) || (state_q == S_STEP_EXEC);
    halt_accept  = advance && i_halt_decoded && !i_stall;
    count_en     = advance || (state_q == S_DRAIN);
    o_haltsignal = !advance;
    o_flush      = advance && !i_stall && (i_jump || i_branch_taken || i_halt_decoded);
    if (i_jump) begin
      o_pc_mux = i_jump_target;
    end else if (i_branch_taken) begin
      o_pc_mux = i_branch_target;
    end else begin
      o_pc_mux = i_pc + DATA_WIDTH'(4);  // wraps naturally at 2^DATA_WIDTH
    end
  end

  // Next-state, drain counter and cycle counter logic.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = i_step_mode ? S_STEP_WAIT : S_RUN;
          count_d = {COUNT_WIDTH{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (halt_accept) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_STEP_WAIT: begin
        if (i_step) begin
          state_d = S_STEP_EXEC;
        end else begin
          state_d = S_STEP_WAIT;
        end
      end
      S_STEP_EXEC: begin
        if (halt_accept) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = S_STEP_WAIT;
        end
      end
      S_DRAIN: begin
        if (drain_q == {DRAIN_W{1'b0}}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        drain_d = {DRAIN_W{1'b0}};
      end
    endcase
    // Executed-cycle count saturates instead of wrapping.
    if (count_en && (count_q != CNT_MAX)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end else begin
      count_d = count_d;
    end
    done_d = (state_d == S_DONE);
  end

  // State, counters and done flag; synchronous reset discards any drain in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      drain_q <= {DRAIN_W{1'b0}};
      count_q <= {COUNT_WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign o_state       = state_q;
  assign o_cycle_count = count_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_step_mode, i_step, i_stall;
  logic        i_branch_taken, i_jump, i_halt_decoded;
  logic [31:0] i_pc, i_branch_target, i_jump_target;

  logic [31:0] a_pc_mux, b_pc_mux;
  logic        a_halt, a_flush, a_done, b_halt, b_flush, b_done;
  logic [2:0]  a_state, b_state;
  logic [31:0] a_count;
  logic [3:0]  b_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        jump;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic [31:0] pc;
    logic        stall;
    logic [31:0] exp_mux;
    logic        exp_flush;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] mux;
    logic        flush;
    logic        halt;
    logic [2:0]  state;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pc_sequencer #(.DATA_WIDTH(32), .DRAIN_CYCLES(3), .COUNT_WIDTH(32)) dut_a (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_pc(i_pc), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_branch_target(i_branch_target), .i_jump(i_jump), .i_jump_target(i_jump_target),
    .i_halt_decoded(i_halt_decoded), .o_pc_mux(a_pc_mux), .o_haltsignal(a_halt),
    .o_flush(a_flush), .o_state(a_state), .o_cycle_count(a_count), .o_done(a_done)
  );

  pc_sequencer #(.DATA_WIDTH(32), .DRAIN_CYCLES(3), .COUNT_WIDTH(4)) dut_b (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_pc(i_pc), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_branch_target(i_branch_target), .i_jump(i_jump), .i_jump_target(i_jump_target),
    .i_halt_decoded(i_halt_decoded), .o_pc_mux(b_pc_mux), .o_haltsignal(b_halt),
    .o_flush(b_flush), .o_state(b_state), .o_cycle_count(b_count), .o_done(b_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic edge_t;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0; i_stall = 1'b0;
    i_branch_taken = 1'b0; i_jump = 1'b0; i_halt_decoded = 1'b0;
    i_pc = 32'h0; i_branch_target = 32'h0; i_jump_target = 32'h0;
  endtask

  task automatic apply_reset;
    i_reset = 1'b1;
    clear_inputs();
    edge_t();
    settle();
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_halt", 32'(a_halt), 32'd1);
    check("rst_flush", 32'(a_flush), 32'd0);
    check("rst_count", a_count, 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_count_b", 32'(b_count), 32'd0);
    edge_t();
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    // {jump, jt, br, bt, pc, stall, exp_mux, exp_flush}
    vecs[0] = '{1'b1, 32'h40, 1'b1, 32'h80, 32'h100,      1'b0, 32'h40,   1'b1};
    vecs[1] = '{1'b0, 32'h40, 1'b0, 32'h80, 32'hFFFFFFFC, 1'b0, 32'h0,    1'b0};
    vecs[2] = '{1'b0, 32'h40, 1'b1, 32'h80, 32'h100,      1'b0, 32'h80,   1'b1};
    vecs[3] = '{1'b1, 32'h40, 1'b0, 32'h80, 32'h100,      1'b1, 32'h40,   1'b0};
    vecs[4] = '{1'b0, 32'h40, 1'b1, 32'h88, 32'h100,      1'b1, 32'h88,   1'b0};
    vecs[5] = '{1'b0, 32'h40, 1'b0, 32'h80, 32'h1234,     1'b0, 32'h1238, 1'b0};

    apply_reset();

    // Continuous start
    i_start = 1'b1; i_pc = 32'h10;
    settle();
    check("idle_halt", 32'(a_halt), 32'd1);
    edge_t();
    i_start = 1'b0;
    settle();
    check("run_state", 32'(a_state), 32'd1);
    check("run_halt", 32'(a_halt), 32'd0);
    check("run_mux", a_pc_mux, 32'h14);
    check("run_count0", a_count, 32'd0);

    // Next-PC / flush table in RUN, expectations queued at drive time
    for (int i = 0; i < 6; i++) begin
      edge_t();
      i_jump = vecs[i].jump; i_jump_target = vecs[i].jt;
      i_branch_taken = vecs[i].br; i_branch_target = vecs[i].bt;
      i_pc = vecs[i].pc; i_stall = vecs[i].stall;
      sb_q.push_back('{$sformatf("vec%0d", i), vecs[i].exp_mux, vecs[i].exp_flush, 1'b0, 3'd1});
      settle();
      e = sb_q.pop_front();
      check({e.name, "_mux"}, a_pc_mux, e.mux);
      check({e.name, "_flush"}, 32'(a_flush), 32'(e.flush));
      check({e.name, "_halt"}, 32'(a_halt), 32'(e.halt));
      check({e.name, "_state"}, 32'(a_state), 32'(e.state));
    end
    check("table_count", a_count, 32'd6);

    // HALT held off by stall, then accepted and drained
    edge_t();
    clear_inputs();
    i_halt_decoded = 1'b1; i_stall = 1'b1; i_pc = 32'h200;
    settle();
    check("halt_stall_flush", 32'(a_flush), 32'd0);
    check("halt_stall_state", 32'(a_state), 32'd1);
    check("halt_stall_mux", a_pc_mux, 32'h204);
    edge_t();
    i_stall = 1'b0;
    settle();
    check("halt_go_state", 32'(a_state), 32'd1);
    check("halt_go_flush", 32'(a_flush), 32'd1);
    check("halt_go_count", a_count, 32'd8);
    edge_t();
    i_halt_decoded = 1'b0;
    settle();
    check("drain1_state", 32'(a_state), 32'd4);
    check("drain1_halt", 32'(a_halt), 32'd1);
    check("drain1_flush", 32'(a_flush), 32'd0);
    edge_t();
    settle();
    check("drain2_state", 32'(a_state), 32'd4);
    edge_t();
    settle();
    check("drain3_state", 32'(a_state), 32'd4);
    check("drain3_done", 32'(a_done), 32'd0);
    edge_t();
    i_jump = 1'b1;
    settle();
    check("done_state", 32'(a_state), 32'd5);
    check("done_done", 32'(a_done), 32'd1);
    check("done_count", a_count, 32'd12);
    check("done_halt", 32'(a_halt), 32'd1);
    check("done_flush", 32'(a_flush), 32'd0);
    i_jump = 1'b0;
    i_start = 1'b1;
    edge_t();
    i_start = 1'b0;
    settle();
    check("done_start_state", 32'(a_state), 32'd5);
    check("done_start_done", 32'(a_done), 32'd1);
    check("done_start_count", a_count, 32'd12);

    // Reset while draining with counter at 1
    apply_reset();
    i_start = 1'b1;
    edge_t();
    i_start = 1'b0; i_halt_decoded = 1'b1;
    settle();
    check("r5_flush", 32'(a_flush), 32'd1);
    edge_t();
    i_halt_decoded = 1'b0;
    settle();
    check("r5_drain_a", 32'(a_state), 32'd4);
    edge_t();
    i_reset = 1'b1;
    settle();
    check("r5_drain_b", 32'(a_state), 32'd4);
    edge_t();
    i_reset = 1'b0;
    settle();
    check("r5_state", 32'(a_state), 32'd0);
    check("r5_done", 32'(a_done), 32'd0);
    check("r5_count", a_count, 32'd0);
    check("r5_halt", 32'(a_halt), 32'd1);
    edge_t();
    settle();
    check("r5_idle_hold", 32'(a_state), 32'd0);

    // Single-step mode
    i_start = 1'b1; i_step_mode = 1'b1;
    edge_t();
    i_start = 1'b0; i_step_mode = 1'b0;
    settle();
    check("sw_state", 32'(a_state), 32'd2);
    check("sw_halt", 32'(a_halt), 32'd1);
    check("sw_count", a_count, 32'd0);
    edge_t();
    i_step = 1'b1; i_pc = 32'h30;
    settle();
    check("sw_hold_state", 32'(a_state), 32'd2);
    edge_t();
    settle();
    check("se1_state", 32'(a_state), 32'd3);
    check("se1_halt", 32'(a_halt), 32'd0);
    check("se1_mux", a_pc_mux, 32'h34);
    check("se1_count", a_count, 32'd0);
    edge_t();
    i_step = 1'b0;
    settle();
    check("sw2_state", 32'(a_state), 32'd2);
    check("sw2_halt", 32'(a_halt), 32'd1);
    check("sw2_count", a_count, 32'd1);
    edge_t();
    settle();
    check("sw_ignored_step", 32'(a_state), 32'd2);
    check("sw_ignored_count", a_count, 32'd1);
    i_step = 1'b1;
    edge_t();
    i_step = 1'b0;
    settle();
    check("se2_state", 32'(a_state), 32'd3);
    edge_t();
    settle();
    check("sw3_state", 32'(a_state), 32'd2);
    check("sw3_count", a_count, 32'd2);
    i_step = 1'b1;
    edge_t();
    i_step = 1'b0; i_halt_decoded = 1'b1;
    settle();
    check("se3_state", 32'(a_state), 32'd3);
    check("se3_flush", 32'(a_flush), 32'd1);
    edge_t();
    i_halt_decoded = 1'b0;
    settle();
    check("sdrain_state", 32'(a_state), 32'd4);
    check("sdrain_count", a_count, 32'd3);
    edge_t();
    edge_t();
    edge_t();
    settle();
    check("sdone_state", 32'(a_state), 32'd5);
    check("sdone_done", 32'(a_done), 32'd1);
    check("sdone_count", a_count, 32'd6);

    // Saturation with a 4-bit counter
    apply_reset();
    i_start = 1'b1;
    edge_t();
    i_start = 1'b0;
    repeat (14) edge_t();
    settle();
    check("sat_b14", 32'(b_count), 32'd14);
    check("sat_a14", a_count, 32'd14);
    edge_t();
    settle();
    check("sat_b15", 32'(b_count), 32'd15);
    repeat (5) edge_t();
    settle();
    check("sat_b20", 32'(b_count), 32'd15);
    check("sat_a20", a_count, 32'd20);
    check("sat_b_state", 32'(b_state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
